regfile_write_arbiter: RTL and testbench

- Shares the single write port of the CPU register file between several writeback sources, such as the ALU, the load unit and the link/PC path.
- Each cycle it grants at most one requester using round-robin priority.
- The winning write is registered toward the register file's per-register write enables and data, with 1-cycle latency.
- Optional read-only R0 suppression and a pipeline stall input.

---
 rtl/regfile_write_arbiter_if.sv | 27 ++
 rtl/regfile_write_arbiter.sv | 82 ++++++++
 tb/tb_regfile_write_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus between the writeback sources and the register
// file write arbiter, plus the registered write port toward the regfile.
interface regfile_write_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int N     = 16,
  parameter int A     = 3
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*A-1:0] req_addr;
  logic [N_REQ*N-1:0] req_data;
  logic               stall;
  logic [N_REQ-1:0]   gnt;
  logic               wr_en;
  logic [A-1:0]       wr_addr;
  logic [N-1:0]       wr_data;
  logic [2:0]         wr_src;

  modport master (
    output req, req_addr, req_data, stall,
    input  gnt, wr_en, wr_addr, wr_data, wr_src
  );

  modport slave (
    input  req, req_addr, req_data, stall,
    output gnt, wr_en, wr_addr, wr_data, wr_src
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between
// several writeback sources; the winning write is registered (1 cycle).
module regfile_write_arbiter #(
  parameter int N_REQ   = 3,
  parameter int N       = 16,
  parameter int A       = 3,
  parameter int ZERO_RO = 1
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    r_ptr;
  logic             r_wr_en;
  logic [A-1:0]     r_wr_addr;
  logic [N-1:0]     r_wr_data;
  logic [2:0]       r_wr_src;

  logic [PW:0]      w_idx;
  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_ptr_nxt;
  logic             w_any;
  logic             w_grant;
  logic             w_wen;
  logic [N_REQ-1:0] w_gnt;
  logic [A-1:0]     w_addr;
  logic [N-1:0]     w_data;

  // Scan offsets high to low so the closest set bit to ptr wins last.
  always_comb begin
    w_idx = '0;
    w_win = '0;
    w_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(N_REQ))
        w_idx = w_idx - (PW+1)'(N_REQ);
      if (bus.req[w_idx[PW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    w_gnt   = '0;
    w_grant = w_any && !bus.stall && rst;
    if (w_grant)
      w_gnt[w_win] = 1'b1;
  end

  assign w_addr    = bus.req_addr[int'(w_win)*A +: A];
  assign w_data    = bus.req_data[int'(w_win)*N +: N];
  assign w_ptr_nxt = (int'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;
  assign w_wen     = !((ZERO_RO != 0) && (w_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_src  <= '0;
    end else if (w_grant) begin
      r_ptr     <= w_ptr_nxt;
      r_wr_en   <= w_wen;
      r_wr_addr <= w_addr;
      r_wr_data <= w_data;
      r_wr_src  <= 3'(w_win);
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign bus.gnt     = w_gnt;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign bus.wr_src  = r_wr_src;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a queue scoreboard
// and an independent write-port monitor.
module tb_regfile_write_arbiter;
  localparam int NR = 3;
  localparam int NW = 16;
  localparam int AW = 3;

  typedef struct {
    logic [AW-1:0] a;
    logic [NW-1:0] d;
    logic [2:0]    s;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.N_REQ(NR), .N(NW), .A(AW)) bus0 ();
  regfile_write_arbiter_if #(.N_REQ(NR), .N(NW), .A(AW)) bus1 ();

  regfile_write_arbiter #(
    .N_REQ(NR), .N(NW), .A(AW), .ZERO_RO(1)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );

  regfile_write_arbiter #(
    .N_REQ(NR), .N(NW), .A(AW), .ZERO_RO(0)
  ) u_dut_nz (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  logic [AW-1:0] t_addr [NR];
  logic [NW-1:0] t_data [NR];

  always_comb begin
    bus0.req_addr = '0;
    bus0.req_data = '0;
    for (int i = 0; i < NR; i++) begin
      bus0.req_addr[i*AW +: AW] = t_addr[i];
      bus0.req_data[i*NW +: NW] = t_data[i];
    end
  end

  assign bus1.req      = bus0.req;
  assign bus1.req_addr = bus0.req_addr;
  assign bus1.req_data = bus0.req_data;
  assign bus1.stall    = bus0.stall;

  wr_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [NR-1:0] rq,
                      input logic st, input logic [NR-1:0] eg,
                      input int ew);
    @(posedge clk);
    #1;
    rst       = r;
    bus0.req  = rq;
    bus0.stall = st;
    @(negedge clk);
    chk("gnt", 32'(bus0.gnt), 32'(eg));
    if (ew >= 0)
      chk("wr_en", 32'(bus0.wr_en), 32'(ew));
    for (int i = 0; i < NR; i++)
      if (eg[i] && t_addr[i] != '0)
        q.push_back('{a: t_addr[i], d: t_data[i], s: 3'(i)});
  endtask

  initial begin : monitor
    wr_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst && bus0.wr_en) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h src %0d expected none",
                   bus0.wr_addr, bus0.wr_data, bus0.wr_src);
        end else begin
          e = q.pop_front();
          chk("wr_addr", 32'(bus0.wr_addr), 32'(e.a));
          chk("wr_data", 32'(bus0.wr_data), 32'(e.d));
          chk("wr_src", 32'(bus0.wr_src), 32'(e.s));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus0.req   = '0;
    bus0.stall = 1'b0;
    t_addr[0] = 3'd1; t_data[0] = 16'hA000;
    t_addr[1] = 3'd2; t_data[1] = 16'hA001;
    t_addr[2] = 3'd3; t_data[2] = 16'hA002;

    // Reset held with all requesting
    step(1'b0, 3'b111, 1'b0, 3'b000, 0);
    step(1'b0, 3'b111, 1'b0, 3'b000, 0);
    chk("rst_wr_addr", 32'(bus0.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus0.wr_data), 32'd0);
    chk("rst_wr_src", 32'(bus0.wr_src), 32'd0);
    step(1'b1, 3'b111, 1'b0, 3'b001, 0);
    step(1'b1, 3'b111, 1'b0, 3'b010, 1);
    step(1'b1, 3'b111, 1'b0, 3'b100, 1);
    step(1'b1, 3'b111, 1'b0, 3'b001, 1);
    step(1'b1, 3'b000, 1'b0, 3'b000, 1);

    // Single requester
    t_addr[1] = 3'd5; t_data[1] = 16'hBEEF;
    step(1'b1, 3'b010, 1'b0, 3'b010, 0);
    step(1'b1, 3'b000, 1'b0, 3'b000, 1);
    step(1'b1, 3'b000, 1'b0, 3'b000, 0);

    // R0 suppression, ptr is 2 here
    t_addr[0] = 3'd0; t_data[0] = 16'h1234;
    step(1'b1, 3'b001, 1'b0, 3'b001, 0);
    step(1'b1, 3'b000, 1'b0, 3'b000, 0);
    chk("nz_wr_en", 32'(bus1.wr_en), 32'd1);
    chk("nz_wr_addr", 32'(bus1.wr_addr), 32'd0);
    chk("nz_wr_data", 32'(bus1.wr_data), 32'h1234);
    t_addr[0] = 3'd1;
    step(1'b1, 3'b111, 1'b0, 3'b010, 0);
    step(1'b1, 3'b100, 1'b0, 3'b100, 1);

    // Stall with ptr at 0; the last pre-stall write still lands
    step(1'b1, 3'b101, 1'b1, 3'b000, 1);
    step(1'b1, 3'b101, 1'b1, 3'b000, 0);
    step(1'b1, 3'b101, 1'b1, 3'b000, 0);
    step(1'b1, 3'b101, 1'b0, 3'b001, 0);
    step(1'b1, 3'b100, 1'b0, 3'b100, 1);

    // req[2] held, req[0] toggling; ptr wraps 2 -> 0
    step(1'b1, 3'b101, 1'b0, 3'b001, 1);
    step(1'b1, 3'b100, 1'b0, 3'b100, 1);
    step(1'b1, 3'b101, 1'b0, 3'b001, 1);
    step(1'b1, 3'b100, 1'b0, 3'b100, 1);
    step(1'b1, 3'b011, 1'b0, 3'b001, 1);
    step(1'b1, 3'b011, 1'b0, 3'b010, 1);
    step(1'b1, 3'b011, 1'b0, 3'b001, 1);
    step(1'b1, 3'b110, 1'b0, 3'b010, 1);
    step(1'b1, 3'b110, 1'b0, 3'b100, 1);
    step(1'b1, 3'b000, 1'b0, 3'b000, 1);

    // Async reset while wr_en is high
    step(1'b1, 3'b010, 1'b0, 3'b010, 0);
    @(posedge clk);
    #3;
    chk("pre_rst_wr_en", 32'(bus0.wr_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_wr_en", 32'(bus0.wr_en), 32'd0);
    chk("async_wr_addr", 32'(bus0.wr_addr), 32'd0);
    chk("async_wr_data", 32'(bus0.wr_data), 32'd0);
    chk("async_gnt", 32'(bus0.gnt), 32'd0);
    bus0.req = '0;
    step(1'b1, 3'b000, 1'b0, 3'b000, 0);
    step(1'b1, 3'b110, 1'b0, 3'b010, 0);
    step(1'b1, 3'b000, 1'b0, 3'b000, 1);
    step(1'b1, 3'b000, 1'b0, 3'b000, 0);
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
